// File: rtl/des_ctrl_pkg.sv
// Shared definitions for the DES round controller.
//   - state_e        : controller state encoding (3-bit)
//   - NUM_ROUNDS     : number of DES rounds (16)
//   - RND_W          : width of the round-number field
//   - ENC/DEC_SHIFT_TBL : per-round C/D rotate amounts; entry [0] is round 1
package des_ctrl_pkg;

  localparam int unsigned NUM_ROUNDS = 16;
  localparam int unsigned RND_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  // Listed from round 16 (MSB) down to round 1 (LSB), so index = round - 1.
  localparam logic [NUM_ROUNDS-1:0][1:0] ENC_SHIFT_TBL = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  // Decryption walks the key schedule backwards: round 1 uses K16 directly
  // (no rotate) and later rounds undo the encrypt shifts in reverse order.
  localparam logic [NUM_ROUNDS-1:0][1:0] DEC_SHIFT_TBL = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
  };

endpackage

// File: rtl/des_key_shift_sched.sv
// Combinational key-schedule rotate lookup.
// Ports:
//   round_num_i : current round, 1..16 (any other value yields 0)
//   decrypt_i   : 0 = encrypt schedule, 1 = decrypt schedule
//   key_shift_o : C/D rotate amount for that round (0, 1 or 2)
module des_key_shift_sched
  import des_ctrl_pkg::*;
(
  input  logic [RND_W-1:0] round_num_i,
  input  logic             decrypt_i,
  output logic [1:0]       key_shift_o
);

  logic       in_range;
  logic [3:0] idx;

  always_comb begin
    key_shift_o = '0;
    in_range    = (round_num_i >= RND_W'(1)) && (round_num_i <= RND_W'(NUM_ROUNDS));
    idx         = 4'(round_num_i - RND_W'(1));
    if (in_range) begin
      key_shift_o = decrypt_i ? DEC_SHIFT_TBL[idx] : ENC_SHIFT_TBL[idx];
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for an iterative single-round DES datapath.
// Accepts one block per IN_VALID/IN_READY handshake, strobes the datapath
// load, steps it through 16 rounds of ROUND_CYCLES clocks each, strobes the
// final permutation and holds OUT_VALID until the host takes the result.
// Ports:
//   CLK, RESET            : clock (rising edge), async active-high reset
//   IN_VALID/IN_READY     : block request handshake (ready only in IDLE)
//   DECRYPT               : mode, latched on the accepting edge
//   ABORT                 : synchronous abort back to IDLE
//   LOAD_EN               : IP(data)->L/R, PC1(key)->C/D strobe
//   ROUND_EN, ROUND_NUM   : round commit strobe and current round (1..16)
//   KEY_SHIFT, KEY_DIR    : C/D rotate amount (valid with ROUND_EN) and direction
//   LAST_ROUND            : round-16 commit, datapath skips the L/R swap
//   FP_EN                 : final-permutation strobe into output register
//   OUT_VALID/OUT_READY   : result handshake
//   BUSY                  : any state other than IDLE
module des_round_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_CYCLES = 1,
  parameter int unsigned CNT_W        = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic       DECRYPT,
  input  logic       ABORT,
  output logic       LOAD_EN,
  output logic       ROUND_EN,
  output logic [4:0] ROUND_NUM,
  output logic [1:0] KEY_SHIFT,
  output logic       KEY_DIR,
  output logic       LAST_ROUND,
  output logic       FP_EN,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUND_CYCLES - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             mode_q, mode_d;
  logic             round_end;
  logic [1:0]       sched_shift;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
    end
  end

  assign round_end = (state_q == ST_ROUND) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    mode_d  = mode_q;

    case (state_q)
      ST_IDLE: begin
        // ABORT on the same edge blocks the accept.
        if (IN_VALID && !ABORT) begin
          state_d = ST_LOAD;
          mode_d  = DECRYPT;
        end
      end
      ST_LOAD: begin
        state_d = ST_ROUND;
        cnt_d   = '0;
        rnd_d   = RND_W'(1);
      end
      ST_ROUND: begin
        if (round_end) begin
          cnt_d = '0;
          if (rnd_q == RND_LAST) begin
            state_d = ST_FINAL;
            rnd_d   = '0;
          end else begin
            rnd_d = rnd_q + RND_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FINAL: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rnd_d   = '0;
      end
    endcase

    // Abort overrides every non-IDLE transition, including a pending result.
    if (ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      rnd_d   = '0;
    end
  end

  des_key_shift_sched u_sched (
    .round_num_i (rnd_q),
    .decrypt_i   (mode_q),
    .key_shift_o (sched_shift)
  );

  // Outputs decode registered state only, so RESET clears them asynchronously.
  assign IN_READY   = (state_q == ST_IDLE);
  assign BUSY       = (state_q != ST_IDLE);
  assign LOAD_EN    = (state_q == ST_LOAD);
  assign ROUND_EN   = round_end;
  assign ROUND_NUM  = (state_q == ST_ROUND) ? rnd_q : '0;
  assign KEY_SHIFT  = round_end ? sched_shift : '0;
  assign KEY_DIR    = (state_q != ST_IDLE) && mode_q;
  assign LAST_ROUND = round_end && (rnd_q == RND_LAST);
  assign FP_EN      = (state_q == ST_FINAL);
  assign OUT_VALID  = (state_q == ST_OUT);

endmodule

// File: tb/tb_des_round_ctrl.sv
module tb_des_round_ctrl;

  typedef struct {
    int unsigned rnd;
    int unsigned sh;
    bit          last;
    bit          dir;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid   [2];
  logic       in_ready   [2];
  logic       decrypt    [2];
  logic       abort      [2];
  logic       load_en    [2];
  logic       round_en   [2];
  logic [4:0] round_num  [2];
  logic [1:0] key_shift  [2];
  logic       key_dir    [2];
  logic       last_round [2];
  logic       fp_en      [2];
  logic       out_valid  [2];
  logic       out_ready  [2];
  logic       busy       [2];

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  des_round_ctrl #(.ROUND_CYCLES(1), .CNT_W(3)) u_dut1 (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .DECRYPT(decrypt[0]), .ABORT(abort[0]), .LOAD_EN(load_en[0]),
    .ROUND_EN(round_en[0]), .ROUND_NUM(round_num[0]), .KEY_SHIFT(key_shift[0]),
    .KEY_DIR(key_dir[0]), .LAST_ROUND(last_round[0]), .FP_EN(fp_en[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .BUSY(busy[0])
  );

  des_round_ctrl #(.ROUND_CYCLES(3), .CNT_W(2)) u_dut3 (
    .CLK(clk), .RESET(rst), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .DECRYPT(decrypt[1]), .ABORT(abort[1]), .LOAD_EN(load_en[1]),
    .ROUND_EN(round_en[1]), .ROUND_NUM(round_num[1]), .KEY_SHIFT(key_shift[1]),
    .KEY_DIR(key_dir[1]), .LAST_ROUND(last_round[1]), .FP_EN(fp_en[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .BUSY(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // DES key schedule: single rotates at rounds 1,2,9,16; decrypt starts unrotated.
  function automatic int unsigned exp_shift(input int unsigned r, input bit dec);
    if (dec && r == 1) return 0;
    if (r == 1 || r == 2 || r == 9 || r == 16) return 1;
    return 2;
  endfunction

  task automatic push_rounds(input bit dec, input int unsigned upto);
    for (int unsigned r = 1; r <= upto; r++)
      sb_q.push_back('{rnd: r, sh: exp_shift(r, dec), last: (r == 16), dir: dec});
  endtask

  // Scoreboard: every round commit on either instance pops one expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (round_en[k]) begin
        if (sb_q.size() == 0) begin
          chk("sb_extra", round_en[k], 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_round", round_num[k], mon_e.rnd);
          chk("sb_shift", key_shift[k], mon_e.sh);
          chk("sb_last",  last_round[k], mon_e.last);
          chk("sb_dir",   key_dir[k], mon_e.dir);
        end
      end
    end
  end

  task automatic run_block(input int k, input bit dec, input int rc,
                           input int hold, input bit chain);
    int n, nre, nfp, nlast, fp_at, last_re, sum;
    int gap_bad, ks_bad, load_bad, rn_bad, exp_rn;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rdy_wait", in_ready[k], 1);
    push_rounds(dec, 16);
    in_valid[k] = 1'b1;
    decrypt[k]  = dec;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    decrypt[k]  = ~dec;
    chk("load_en", load_en[k], 1);
    chk("in_ready_lo", in_ready[k], 0);
    chk("busy", busy[k], 1);
    chk("key_dir", key_dir[k], dec);
    n = 0; nre = 0; nfp = 0; nlast = 0; fp_at = -1; last_re = 0; sum = 0;
    gap_bad = 0; ks_bad = 0; load_bad = 0; rn_bad = 0;
    while (!out_valid[k] && n < 400) begin
      if (round_en[k]) begin
        nre++;
        sum += int'(key_shift[k]);
        if (n - last_re != rc) gap_bad++;
        last_re = n;
      end else if (key_shift[k] != 2'd0) begin
        ks_bad++;
      end
      if (last_round[k]) nlast++;
      if (fp_en[k]) begin nfp++; fp_at = n; end
      if (n > 0 && load_en[k]) load_bad++;
      exp_rn = (n >= 1 && n <= 16 * rc) ? (n - 1) / rc + 1 : 0;
      if (int'(round_num[k]) != exp_rn) rn_bad++;
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 2 + 16 * rc);
    chk("round_cnt", nre, 16);
    chk("round_gap", gap_bad, 0);
    chk("shift_sum", sum, dec ? 27 : 28);
    chk("shift_idle", ks_bad, 0);
    chk("last_cnt", nlast, 1);
    chk("fp_cnt", nfp, 1);
    chk("fp_at", fp_at, 16 * rc + 1);
    chk("load_once", load_bad, 0);
    chk("rnum_seq", rn_bad, 0);
    chk("sb_empty", sb_q.size(), 0);
    for (int i = 0; i < hold; i++) begin
      chk("ov_hold", out_valid[k], 1);
      @(posedge clk); #1;
    end
    chk("ov_up", out_valid[k], 1);
    chk("in_ready_out", in_ready[k], 0);
    out_ready[k] = 1'b1;
    if (chain) in_valid[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("ov_drop", out_valid[k], 0);
    chk("rdy_back", in_ready[k], 1);
    chk("no_direct_load", load_en[k], 0);
  endtask

  task automatic quiet(input int k, input int cycles);
    int ev;
    ev = 0;
    for (int i = 0; i < cycles; i++) begin
      if (round_en[k] || fp_en[k] || out_valid[k] || load_en[k] || busy[k]) ev++;
      @(posedge clk); #1;
    end
    chk("quiet", ev, 0);
  endtask

  task automatic start_to_round7(input int k);
    int n;
    in_valid[k] = 1'b1;
    decrypt[k]  = 1'b0;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    n = 0;
    while (round_num[k] != 5'd7 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("r7_reach", round_num[k], 7);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; decrypt[k] = 1'b0; abort[k] = 1'b0; out_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready[k], 1);
      chk("rst_busy", busy[k], 0);
      chk("rst_load", load_en[k], 0);
      chk("rst_round_en", round_en[k], 0);
      chk("rst_round_num", round_num[k], 0);
      chk("rst_key_dir", key_dir[k], 0);
      chk("rst_fp", fp_en[k], 0);
      chk("rst_out_valid", out_valid[k], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_block(0, 1'b0, 1, 0, 1'b0);
    run_block(0, 1'b1, 1, 0, 1'b0);
    run_block(1, 1'b0, 3, 0, 1'b0);
    run_block(1, 1'b1, 3, 2, 1'b0);

    // Backpressure, then a request held high across the OUT->IDLE edge.
    run_block(0, 1'b0, 1, 10, 1'b1);
    run_block(0, 1'b1, 1, 0, 1'b0);

    // ABORT in round 7.
    push_rounds(1'b0, 7);
    start_to_round7(0);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    chk("abort_idle", in_ready[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_rnum", round_num[0], 0);
    quiet(0, 20);
    chk("abort_sb", sb_q.size(), 0);
    run_block(0, 1'b1, 1, 0, 1'b0);

    // RESET in round 7: outputs drop without a clock edge.
    push_rounds(1'b0, 6);
    start_to_round7(0);
    rst = 1'b1;
    #1;
    chk("rst_mid_round_en", round_en[0], 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_ready", in_ready[0], 1);
    chk("rst_mid_rnum", round_num[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    quiet(0, 20);
    chk("rst_sb", sb_q.size(), 0);
    run_block(0, 1'b0, 1, 0, 1'b0);

    // ABORT together with IN_VALID while idle.
    in_valid[0] = 1'b1;
    abort[0]    = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    abort[0]    = 1'b0;
    chk("idle_abort_load", load_en[0], 0);
    chk("idle_abort_ready", in_ready[0], 1);
    chk("idle_abort_busy", busy[0], 0);
    quiet(0, 5);
    run_block(1, 1'b0, 3, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
